// File: rtl/memory_axis_wr_gen_if.sv
// AXI-Stream beat bus driven by the table-driven stimulus generator.
interface memory_axis_wr_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/memory_axis_wr_gen.sv
// Table-driven AXI-Stream master stimulus generator.
// A writable control/data table is walked from start_addr; each entry becomes
// one beat, optionally preceded by idle gap cycles. An END entry terminates
// the walk or wraps back to start_addr when looping is enabled.
module memory_axis_wr_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  tx_mac_aclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  loop_en,
  input  logic                  stop,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [31:0]           mem_wctrl,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  memory_axis_wr_gen_if.master  m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_SEND
  } state_t;

  logic [31:0]           r_ctrlMem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dataMem [DEPTH];

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_startAddr;
  logic [7:0]            r_cnt;
  logic                  r_stopPending;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tlast;
  logic                  r_tvalid;
  logic                  r_done;
  logic [15:0]           r_frameCnt;

  logic [ADDR_WIDTH-1:0] w_ptrNext;
  logic [31:0]           w_ctrlCur;
  logic [31:0]           w_ctrlNext;
  logic [DATA_WIDTH-1:0] w_dataCur;
  logic [DATA_WIDTH-1:0] w_dataNext;
  logic                  w_curEnd;
  logic [7:0]            w_curGap;
  logic                  w_nextEnd;
  logic [7:0]            w_nextGap;
  logic                  w_stopReq;
  logic [15:0]           w_frameCntInc;
  logic                  w_unusedCtrl;

  // The current entry feeds LOAD/GAP; the next entry is the SEND look-ahead
  // that allows back-to-back beats without an idle cycle.
  assign w_ptrNext     = r_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_ctrlCur     = r_ctrlMem[r_ptr];
  assign w_dataCur     = r_dataMem[r_ptr];
  assign w_ctrlNext    = r_ctrlMem[w_ptrNext];
  assign w_dataNext    = r_dataMem[w_ptrNext];
  assign w_curEnd      = w_ctrlCur[31];
  assign w_curGap      = w_ctrlCur[23:16];
  assign w_nextEnd     = w_ctrlNext[31];
  assign w_nextGap     = w_ctrlNext[23:16];
  assign w_stopReq     = r_stopPending | stop;
  assign w_frameCntInc = (r_frameCnt == 16'hFFFF) ? r_frameCnt : r_frameCnt + 16'd1;
  assign w_unusedCtrl  = ^{w_ctrlCur, w_ctrlNext};

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tvalid = r_tvalid;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign frame_cnt     = r_frameCnt;

  // Table write port; contents deliberately survive reset.
  always_ff @(posedge tx_mac_aclk) begin
    if (mem_we) begin
      r_ctrlMem[mem_waddr] <= mem_wctrl;
      r_dataMem[mem_waddr] <= mem_wdata;
    end
  end

  // Walk the table, register each beat and hold it until the sink accepts it.
  always_ff @(posedge tx_mac_aclk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_startAddr   <= '0;
      r_cnt         <= '0;
      r_stopPending <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tlast       <= 1'b0;
      r_tvalid      <= 1'b0;
      r_done        <= 1'b0;
      r_frameCnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && stop) begin
        r_stopPending <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          r_tvalid <= 1'b0;
          if (start) begin
            r_ptr         <= start_addr;
            r_startAddr   <= start_addr;
            r_frameCnt    <= '0;
            r_stopPending <= 1'b0;
            r_state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_curEnd) begin
            if (!loop_en || r_stopPending || (r_ptr == r_startAddr)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_ptr <= r_startAddr;
            end
          end else if (w_curGap != 8'd0) begin
            r_cnt   <= w_curGap - 8'd1;
            r_state <= S_GAP;
          end else begin
            r_tdata  <= w_dataCur;
            r_tkeep  <= w_ctrlCur[KEEP_WIDTH-1:0];
            r_tlast  <= w_ctrlCur[30];
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_GAP: begin
          r_tvalid <= 1'b0;
          if (r_cnt == 8'd0) begin
            r_tdata  <= w_dataCur;
            r_tkeep  <= w_ctrlCur[KEEP_WIDTH-1:0];
            r_tlast  <= w_ctrlCur[30];
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SEND: begin
          if (r_tvalid && m_axis.tready) begin
            if (r_tlast) begin
              r_frameCnt <= w_frameCntInc;
            end
            if (r_tlast && w_stopReq) begin
              r_tvalid <= 1'b0;
              r_state  <= S_IDLE;
              r_done   <= 1'b1;
            end else begin
              r_ptr <= w_ptrNext;
              if (w_nextEnd) begin
                r_tvalid <= 1'b0;
                r_state  <= S_LOAD;
              end else if (w_nextGap != 8'd0) begin
                r_cnt    <= w_nextGap - 8'd1;
                r_tvalid <= 1'b0;
                r_state  <= S_GAP;
              end else begin
                r_tdata  <= w_dataNext;
                r_tkeep  <= w_ctrlNext[KEEP_WIDTH-1:0];
                r_tlast  <= w_ctrlNext[30];
                r_tvalid <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_axis_wr_gen.md
Name: memory_axis_wr_gen

Overview:
Table-driven AXI-Stream master stimulus generator for the LMAC2 AXIS_MASTER test environment. It holds a writable control/data table of 2^ADDR_WIDTH entries. On start, it streams table entries as AXIS beats with full tready backpressure, per-entry idle-gap insertion, tlast framing, optional looping, graceful stop at a frame boundary, and a frame counter.

Parameters:
DATA_WIDTH, 64, tdata width; multiple of 8, maximum 128.
ADDR_WIDTH, 11, table address width; depth = 2^ADDR_WIDTH.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width (derived; do not override).

Ports:
tx_mac_aclk  in  1  TX clock; all logic on rising edge.
reset  in  1  synchronous active-high reset.
start  in  1  begin streaming at start_addr; ignored while busy.
start_addr  in  ADDR_WIDTH  first table entry.
loop_en  in  1  on END entry, restart at start_addr instead of stopping.
stop  in  1  request halt at next frame boundary.
mem_we  in  1  table write enable.
mem_waddr  in  ADDR_WIDTH  table write address.
mem_wctrl  in  32  control word to write.
mem_wdata  in  DATA_WIDTH  data word to write.
m_axis_tdata  out  DATA_WIDTH  beat data.
m_axis_tkeep  out  KEEP_WIDTH  byte enables.
m_axis_tlast  out  1  end of frame.
m_axis_tvalid  out  1  beat valid.
m_axis_tready  in  1  sink ready.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse on return to IDLE (not on reset).
frame_cnt  out  16  frames accepted since last start; saturates at 0xFFFF.

Behaviour:
- Control word fields: [31] END (terminator, never sent); [30] LAST -> tlast; [23:16] GAP, the number of idle cycles before this beat; [KEEP_WIDTH-1:0] tkeep. All other bits are ignored.
- Table arrays use async read and sync write. Table contents are not reset. A write to the entry currently presented does not alter the held outputs.
- Reset values: tvalid=0, tdata=0, tkeep=0, tlast=0, busy=0, done=0, frame_cnt=0, stop_pending=0, ptr=0, state=IDLE.
- States: IDLE, LOAD, GAP, SEND.
- IDLE: tvalid=0. When start=1: ptr<=start_addr, frame_cnt<=0, stop_pending<=0, go to LOAD.
- LOAD: evaluates entry[ptr]. This is one idle cycle.
  - END with (loop_en=0 or stop_pending): go to IDLE and pulse done.
  - END with loop_en=1 and ptr==start_addr: go to IDLE and pulse done (empty-table guard).
  - END with loop_en=1 otherwise: ptr<=start_addr, stay in LOAD.
  - GAP=g>0: cnt<=g-1, go to GAP.
  - Else: register beat into outputs, tvalid<=1, go to SEND.
- GAP: tvalid=0. If cnt==0, register entry[ptr] and go to SEND; else cnt--.
- SEND: outputs are held stable while tvalid=1 and tready=0. On handshake (tvalid & tready):
  - If tlast: frame_cnt++ (saturating).
  - If tlast and (stop_pending or stop): go to IDLE and pulse done.
  - Otherwise ptr<=ptr+1 and look ahead at entry[ptr+1]:
    - non-END with GAP=0: load it directly and stay in SEND (back-to-back, one beat per cycle).
    - non-END with GAP=g>0: cnt<=g-1, tvalid<=0, go to GAP.
    - END: go to LOAD. LOAD then applies the END rules; a loop wrap costs 2 idle cycles.
- Gap timing: exactly g cycles with tvalid=0 between the previous handshake and the gapped beat.
- Start latency: start sampled at edge N gives tvalid=1 after edge N+1+GAP(first entry).
- stop: sampled in any non-IDLE state and latched into stop_pending. It acts only at a tlast handshake or an END entry. It is ignored in IDLE.
- ptr increments modulo 2^ADDR_WIDTH (2047 -> 0).
- busy=1 in LOAD, GAP and SEND. done and busy=0 appear in the same cycle as IDLE entry.
- Reset mid-operation: all outputs return to reset values on the next edge. In-flight beats are discarded.

Test Plan:
- Table: 0..3 data 0xA0..0xA3, entries 1 and 3 LAST, entry 3 tkeep=0x0F, others 0xFF; entry 4 END; tready=1; start at addr 0. Expect 4 beats on consecutive cycles, tvalid rising after edge N+1, tlast on beats 1 and 3, done pulse, frame_cnt=2.
- Same table, tready pattern 1,0,0,1,0,1... Expect each beat held stable until accepted, no beat lost or duplicated, order A0..A3.
- Entry 1 GAP=3. Expect exactly 3 tvalid-low cycles between the beat-0 handshake and beat 1; beat 0 unaffected.
- loop_en=1, 2-beat frame then END. Expect repetition with 2 idle cycles per wrap. Assert stop mid-frame: frame completes, then IDLE with done; frame_cnt equals frames sent.
- start_addr=2046, entries 2046, 2047, 0 (LAST), 1 END. Expect 3 beats with ptr wrap and done.
- Reset during SEND with tvalid=1. Expect tvalid=0, busy=0, frame_cnt=0 next cycle. Separately, start pulsed while busy causes no restart.
